// File: rtl/croc_pkg.sv
// Shared croc SoC types: address-map rule consumed by the bus demultiplexers.
package croc_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

endpackage

// File: rtl/user_pkg.sv
// User-domain address map: subordinate indices, windows and the rule table for user_obi_demux.
package user_pkg;
  import croc_pkg::*;

  localparam int unsigned NumDemuxSbrRules = 1;
  localparam int unsigned NumDemuxSbr      = NumDemuxSbrRules + 1;

  typedef enum int unsigned {
    UserError = 0,
    UserRom   = 1
  } user_demux_outputs_e;

  localparam logic [31:0] UserRomAddrOffset = 32'h2000_0000;
  localparam logic [31:0] UserRomAddrRange  = 32'h0000_1000;

  // end_addr is inclusive, hence the -1
  localparam addr_map_rule_t [NumDemuxSbrRules-1:0] user_addr_map = '{
    '{idx:        UserRom,
      start_addr: UserRomAddrOffset,
      end_addr:   UserRomAddrOffset + UserRomAddrRange - 32'd1}
  };

endpackage

// File: rtl/user_obi_err_sbr.sv
// Error subordinate: grants immediately, answers every request one cycle later with err=1.
module user_obi_err_sbr #(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          IdWidth   = 1,
  parameter logic [DataWidth-1:0] ErrRdata  = 32'hBADCAB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [IdWidth-1:0]   aid_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic [IdWidth-1:0]   rid_o,
  output logic                 err_o
);

  logic               rvalid_d, rvalid_q;
  logic [IdWidth-1:0] rid_d, rid_q;

  assign gnt_o = req_i;

  always_comb begin
    rvalid_d = req_i;
    rid_d    = req_i ? aid_i : rid_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = ErrRdata;
  assign rid_o    = rid_q;
  assign err_o    = rvalid_q;

endmodule

// File: rtl/user_obi_demux.sv
// OBI demux: rule-table decode to NumRules subordinates plus error subordinate at index 0.
// Optional decode-error counter enabled by USER_OBI_DEMUX_ERR_CNT_EN.
module user_obi_demux
  import user_pkg::*;
#(
  parameter int unsigned          NumRules  = NumDemuxSbrRules,
  parameter int unsigned          MaxTrans  = 4,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          IdWidth   = 1,
  parameter logic [DataWidth-1:0] ErrRdata  = 32'hBADCAB1E
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  croc_pkg::addr_map_rule_t [NumRules-1:0] addr_map_i,
  input  logic                                   mgr_req_i,
  output logic                                   mgr_gnt_o,
  input  logic [AddrWidth-1:0]                   mgr_addr_i,
  input  logic                                   mgr_we_i,
  input  logic [DataWidth/8-1:0]                 mgr_be_i,
  input  logic [DataWidth-1:0]                   mgr_wdata_i,
  input  logic [IdWidth-1:0]                     mgr_aid_i,
  output logic                                   mgr_rvalid_o,
  output logic [DataWidth-1:0]                   mgr_rdata_o,
  output logic [IdWidth-1:0]                     mgr_rid_o,
  output logic                                   mgr_err_o,
  output logic [NumRules:0]                      sbr_req_o,
  input  logic [NumRules:0]                      sbr_gnt_i,
  output logic [AddrWidth-1:0]                   sbr_addr_o,
  output logic                                   sbr_we_o,
  output logic [DataWidth/8-1:0]                 sbr_be_o,
  output logic [DataWidth-1:0]                   sbr_wdata_o,
  output logic [IdWidth-1:0]                     sbr_aid_o,
  input  logic [NumRules:0]                      sbr_rvalid_i,
  input  logic [NumRules:0][DataWidth-1:0]       sbr_rdata_i,
  input  logic [NumRules:0][IdWidth-1:0]         sbr_rid_i,
  input  logic [NumRules:0]                      sbr_err_i,
  output logic [15:0]                            err_count_o
);

  localparam int unsigned SelW = $clog2(NumRules + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned CmpW = (AddrWidth > 32) ? AddrWidth : 32;

  typedef logic [SelW-1:0] sel_t;
  typedef logic [CntW-1:0] cnt_t;

  sel_t            dec_idx, sel_d, sel_q;
  cnt_t            cnt_d, cnt_q;
  logic            dec_hit, stall, fwd, hs, rsp;
  logic [CmpW-1:0] addr_ext;

  logic                 err_req, err_gnt, err_rvalid, err_err;
  logic [DataWidth-1:0] err_rdata;
  logic [IdWidth-1:0]   err_rid;

  logic [NumRules:0]                gnt_all, rvalid_all, errb_all;
  logic [NumRules:0][DataWidth-1:0] rdata_all;
  logic [NumRules:0][IdWidth-1:0]   rid_all;

  assign addr_ext = CmpW'(mgr_addr_i);

  // First matching rule in array order wins; out-of-range idx values never match.
  always_comb begin
    dec_idx = '0;
    dec_hit = 1'b0;
    for (int unsigned i = 0; i < NumRules; i++) begin
      if (!dec_hit && (addr_map_i[i].idx <= NumRules) &&
          (addr_ext >= CmpW'(addr_map_i[i].start_addr)) &&
          (addr_ext <= CmpW'(addr_map_i[i].end_addr))) begin
        dec_hit = 1'b1;
        dec_idx = sel_t'(addr_map_i[i].idx);
      end
    end
  end

  assign stall = (cnt_q == cnt_t'(MaxTrans)) || ((cnt_q != '0) && (dec_idx != sel_q));
  assign fwd   = rst_ni & ~stall;

  // Slot 0 of each per-subordinate vector is replaced by the internal error subordinate.
  always_comb begin
    gnt_all       = sbr_gnt_i;
    rvalid_all    = sbr_rvalid_i;
    rdata_all     = sbr_rdata_i;
    rid_all       = sbr_rid_i;
    errb_all      = sbr_err_i;
    gnt_all[0]    = err_gnt;
    rvalid_all[0] = err_rvalid;
    rdata_all[0]  = err_rdata;
    rid_all[0]    = err_rid;
    errb_all[0]   = err_err;
  end

  always_comb begin
    sbr_req_o = '0;
    if (dec_idx != '0) sbr_req_o[dec_idx] = mgr_req_i & fwd;
  end

  assign err_req   = mgr_req_i & fwd & (dec_idx == '0);
  assign mgr_gnt_o = gnt_all[dec_idx] & fwd;
  assign hs        = mgr_req_i & mgr_gnt_o;

  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_wdata_o = mgr_wdata_i;
  assign sbr_aid_o   = mgr_aid_i;

  assign mgr_rvalid_o = rvalid_all[sel_q];
  assign mgr_rdata_o  = rdata_all[sel_q];
  assign mgr_rid_o    = rid_all[sel_q];
  assign mgr_err_o    = errb_all[sel_q];
  assign rsp          = mgr_rvalid_o;

  always_comb begin
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (hs) sel_d = dec_idx;
    unique case ({hs, rsp && (cnt_q != '0)})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  user_obi_err_sbr #(
    .DataWidth (DataWidth),
    .IdWidth   (IdWidth),
    .ErrRdata  (ErrRdata)
  ) i_err_sbr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (err_req),
    .aid_i    (mgr_aid_i),
    .gnt_o    (err_gnt),
    .rvalid_o (err_rvalid),
    .rdata_o  (err_rdata),
    .rid_o    (err_rid),
    .err_o    (err_err)
  );

`ifdef USER_OBI_DEMUX_ERR_CNT_EN
  logic [15:0] err_cnt_d, err_cnt_q;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (hs && (dec_idx == '0) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_count_o = err_cnt_q;
`else
  assign err_count_o = '0;
`endif

`ifndef SYNTHESIS
  rsp_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rsp && (cnt_q == '0)));
`endif

endmodule
